ge_round_driver: RTL and testbench

Initiator side of the stage-chain interface: drives `effort`, `hard`, `random2`, `pass1` and `bonus1` into a combinational stage evaluator and collects its `pass2`/`bonus2` answer. It runs a programmable number of rounds. Each round's `pass2`/`bonus2` is fed back as the next round's `pass1`/`bonus1`. Per-round `hard`/`random2` come from an internal 10-bit LFSR. The block tallies the bonus and reports a final verdict with a one-cycle `done` pulse.

---
 rtl/ge_round_driver.sv | 155 +++++++++++++++
 tb/tb_ge_round_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ge_round_driver.sv
// ---------------------------------------------------------------------------
// ge_round_driver
//
// Initiator for a chain of stage evaluations. A run is requested with
// `start`; the block then presents one round per cycle to an external
// combinational stage evaluator. Each round's answer (pass2/bonus2) becomes
// the next round's carried operands (pass1/bonus1). Per-round difficulty
// and random values come from a 10-bit LFSR seeded at start. The run ends
// after the programmed number of rounds, or as soon as a round fails. A
// one-cycle `done` pulse then announces the verdict.
//
// Ports
//   clk, rst_n        : clock (rising edge), synchronous active-low reset
//   start             : run request, accepted only while idle
//   effort_in  [6:0]  : effort for the run, latched at start
//   num_rounds [3:0]  : number of rounds to run (0..15), latched at start
//   seed       [9:0]  : LFSR seed, latched at start (0 is replaced by 1)
//   effort     [6:0]  : effort presented to the stage
//   hard       [4:0]  : difficulty presented to the stage, LFSR[4:0]
//   random2    [4:0]  : random value presented to the stage, LFSR[9:5]
//   pass1             : carried pass flag presented to the stage
//   bonus1     [1:0]  : carried bonus presented to the stage
//   pass2             : stage pass answer
//   bonus2     [1:0]  : stage bonus answer
//   busy              : high while rounds are being driven
//   done              : one-cycle pulse when a run finishes
//   result_pass       : final pass verdict of the last run
//   bonus_total[5:0]  : sum of captured bonus2 values of the last run
//   rounds_run [3:0]  : number of rounds captured in the last run
// ---------------------------------------------------------------------------
module ge_round_driver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] effort_in,
  input  logic [3:0] num_rounds,
  input  logic [9:0] seed,
  output logic [6:0] effort,
  output logic [4:0] hard,
  output logic [4:0] random2,
  output logic       pass1,
  output logic [1:0] bonus1,
  input  logic       pass2,
  input  logic [1:0] bonus2,
  output logic       busy,
  output logic       done,
  output logic       result_pass,
  output logic [5:0] bonus_total,
  output logic [3:0] rounds_run
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [9:0] lfsr;
  logic [3:0] rounds_tgt;
  logic       last_round;

  // Feedback taps 9 and 6 give a maximal-length 10-bit sequence.
  function automatic logic [9:0] lfsr_next(input logic [9:0] s);
    return {s[8:0], s[9] ^ s[6]};
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is substituted.
  function automatic logic [9:0] seed_fix(input logic [9:0] s);
    return (s == 10'd0) ? 10'h001 : s;
  endfunction

  assign hard    = lfsr[4:0];
  assign random2 = lfsr[9:5];
  assign busy    = (state == S_DRIVE);
  assign done    = (state == S_DONE);

  // A failed round ends the run at once: the pass flag is sticky through
  // the chain, so no later round could recover it. The round target is a
  // copy of num_rounds taken at start, so the run length cannot be
  // disturbed by the input moving mid-run.
  always_comb begin
    last_round = 1'b0;
    state_nxt  = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_rounds == 4'd0) ? S_DONE : S_DRIVE;
        end
      end
      S_DRIVE: begin
        last_round = !pass2 || ((rounds_run + 4'd1) == rounds_tgt);
        if (last_round) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lfsr        <= 10'h001;
      effort      <= 7'd0;
      pass1       <= 1'b0;
      bonus1      <= 2'd0;
      result_pass <= 1'b0;
      bonus_total <= 6'd0;
      rounds_run  <= 4'd0;
      rounds_tgt  <= 4'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            effort      <= effort_in;
            lfsr        <= seed_fix(seed);
            pass1       <= 1'b1;
            bonus1      <= 2'd0;
            bonus_total <= 6'd0;
            rounds_run  <= 4'd0;
            rounds_tgt  <= num_rounds;
            // An empty run trivially passes.
            if (num_rounds == 4'd0) begin
              result_pass <= 1'b1;
            end
          end
        end
        // Capture edge: the stage answer has been stable for a full cycle
        // because every stage operand is a register.
        S_DRIVE: begin
          pass1       <= pass2;
          bonus1      <= bonus2;
          // At most 15 rounds of bonus 3 (45) fit in 6 bits.
          bonus_total <= bonus_total + {4'd0, bonus2};
          rounds_run  <= rounds_run + 4'd1;
          lfsr        <= lfsr_next(lfsr);
          if (last_round) begin
            result_pass <= pass2;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ge_round_driver.sv
module tb_ge_round_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] effort_in;
  logic [3:0] num_rounds;
  logic [9:0] seed;
  logic [6:0] effort;
  logic [4:0] hard;
  logic [4:0] random2;
  logic       pass1;
  logic [1:0] bonus1;
  logic       pass2;
  logic [1:0] bonus2;
  logic       busy;
  logic       done;
  logic       result_pass;
  logic [5:0] bonus_total;
  logic [3:0] rounds_run;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ge_round_driver dut (
    .clk(clk), .rst_n(rst_n), .start(start), .effort_in(effort_in),
    .num_rounds(num_rounds), .seed(seed), .effort(effort), .hard(hard),
    .random2(random2), .pass1(pass1), .bonus1(bonus1), .pass2(pass2),
    .bonus2(bonus2), .busy(busy), .done(done), .result_pass(result_pass),
    .bonus_total(bonus_total), .rounds_run(rounds_run)
  );

  // Stage evaluator: either a small scoring stage, or random answers.
  logic       stage_rand = 1'b0;
  logic       r_pass = 1'b1;
  logic [1:0] r_bonus = 2'd0;
  logic       toy_pass;
  logic [1:0] toy_bonus;
  int         sc;

  always_comb begin
    sc = int'(effort) + int'(random2) - int'(hard);
    if (sc > 127) sc = 127;
    if (sc < 0) sc = 0;
    toy_pass  = pass1 && (sc >= 50) && !(hard[0] && effort >= 7'd90 && effort < 7'd127);
    toy_bonus = (sc == 127) ? 2'd3 : 2'd0;
  end

  assign pass2  = stage_rand ? r_pass : toy_pass;
  assign bonus2 = stage_rand ? r_bonus : toy_bonus;

  // Reference model: a run is described by its latched parameters, the
  // number of LFSR steps taken since the seed and the rounds captured.
  function automatic logic [9:0] lfsr_at(input logic [9:0] s0, input int steps);
    logic [9:0] s;
    s = (s0 == 10'd0) ? 10'h001 : s0;
    for (int i = 0; i < steps; i++) s = {s[8:0], s[9] ^ s[6]};
    return s;
  endfunction

  int         m_run, m_done, m_res, m_tot, m_k, m_n, m_eff, m_p1, m_b1, m_steps;
  logic [9:0] m_seed;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_res = 0; m_tot = 0; m_k = 0; m_n = 0;
      m_eff = 0; m_p1 = 0; m_b1 = 0; m_steps = 0; m_seed = 10'h001;
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (m_run != 0) begin
      m_p1 = int'(pass2);
      m_b1 = int'(bonus2);
      m_tot += int'(bonus2);
      m_k++;
      m_steps++;
      if (!pass2 || m_k == m_n) begin
        m_run = 0; m_done = 1; m_res = int'(pass2);
      end
    end else if (start) begin
      m_eff = int'(effort_in); m_seed = seed; m_steps = 0;
      m_p1 = 1; m_b1 = 0; m_tot = 0; m_k = 0; m_n = int'(num_rounds);
      if (num_rounds == 4'd0) begin
        m_done = 1; m_res = 1;
      end else begin
        m_run = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    logic [9:0] ml;
    if (cmp_en) begin
      ml = lfsr_at(m_seed, m_steps);
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
      chk("effort", 32'(effort), 32'(m_eff));
      chk("hard", 32'(hard), 32'(ml[4:0]));
      chk("random2", 32'(random2), 32'(ml[9:5]));
      chk("pass1", 32'(pass1), 32'(m_p1));
      chk("bonus1", 32'(bonus1), 32'(m_b1));
      chk("result_pass", 32'(result_pass), 32'(m_res));
      chk("bonus_total", 32'(bonus_total), 32'(m_tot));
      chk("rounds_run", 32'(rounds_run), 32'(m_k));
    end
    r_pass  = ($urandom_range(7) != 0);
    r_bonus = 2'($urandom_range(3));
  end

  int         cyc;
  logic [4:0] hard_log[16];
  logic [4:0] rnd_log[16];

  // Requests a run at the current negedge and returns the number of
  // negedges after the start edge until done is seen; ends one cycle
  // later so the next request lands in IDLE.
  task automatic run(input int eff, input int sd, input int n, input bit poke, output int c);
    effort_in  = 7'(eff);
    seed       = 10'(sd);
    num_rounds = 4'(n);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!done && c < 40) begin
      hard_log[c[3:0]] = hard;
      rnd_log[c[3:0]]  = random2;
      @(negedge clk);
      c++;
      if (poke) start = (c == 1);
    end
    start = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL done_timeout: got=no_done want=done within 40 cycles");
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; effort_in = 7'd55; num_rounds = 4'd3; seed = 10'h155;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hard", 32'(hard), 32'd1);
    chk("rst_random2", 32'(random2), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_effort", 32'(effort), 32'd0);
    chk("rst_bonus_total", 32'(bonus_total), 32'd0);
    cmp_en = 1'b1;
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("start_in_reset_ignored", 32'(busy), 32'd0);

    // Early abort on round 0.
    run(100, 10'h001, 5, 1'b0, cyc);
    chk("abort_latency", 32'(cyc), 32'd1);
    chk("abort_result", 32'(result_pass), 32'd0);
    chk("abort_rounds", 32'(rounds_run), 32'd1);
    chk("abort_bonus", 32'(bonus_total), 32'd0);

    // Full run of three rounds.
    run(80, 10'h001, 3, 1'b0, cyc);
    chk("full_latency", 32'(cyc), 32'd3);
    chk("full_hard0", 32'(hard_log[0]), 32'd1);
    chk("full_hard1", 32'(hard_log[1]), 32'd2);
    chk("full_hard2", 32'(hard_log[2]), 32'd4);
    chk("full_result", 32'(result_pass), 32'd1);
    chk("full_bonus", 32'(bonus_total), 32'd0);
    chk("full_rounds", 32'(rounds_run), 32'd3);

    // Bonus round.
    run(127, 10'h020, 1, 1'b0, cyc);
    chk("bonus_hard0", 32'(hard_log[0]), 32'd0);
    chk("bonus_rnd0", 32'(rnd_log[0]), 32'd1);
    chk("bonus_total", 32'(bonus_total), 32'd3);
    chk("bonus_result", 32'(result_pass), 32'd1);

    // Zero rounds.
    run(10, 10'h000, 0, 1'b0, cyc);
    chk("zero_latency", 32'(cyc), 32'd0);
    chk("zero_result", 32'(result_pass), 32'd1);
    chk("zero_rounds", 32'(rounds_run), 32'd0);

    // Start pulsed mid-run is ignored.
    run(80, 10'h001, 4, 1'b1, cyc);
    chk("poke_latency", 32'(cyc), 32'd4);
    chk("poke_rounds", 32'(rounds_run), 32'd4);
    chk("poke_result", 32'(result_pass), 32'd1);
    @(negedge clk);
    chk("poke_no_requeue", 32'(busy), 32'd0);

    // Reset during round 2 of 5.
    effort_in = 7'd80; seed = 10'h001; num_rounds = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rounds", 32'(rounds_run), 32'd0);
    chk("midrst_result", 32'(result_pass), 32'd0);
    chk("midrst_hard", 32'(hard), 32'd1);
    @(negedge clk);
    chk("midrst_no_done", 32'(done), 32'd0);
    run(80, 10'h001, 3, 1'b0, cyc);
    chk("after_rst_latency", 32'(cyc), 32'd3);
    chk("after_rst_rounds", 32'(rounds_run), 32'd3);

    // Randomized runs with random stage answers.
    stage_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      run(int'($urandom_range(127)), int'($urandom_range(1023)), int'($urandom_range(15)),
          bit'($urandom_range(1)), cyc);
      if ($urandom_range(3) == 0) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
